omp_sparse_scatter: RTL and testbench
=====================================

// Module: omp_sparse_scatter
// PURPOSE
//  Parametrised back end of OMP reconstruction. Collects the support set (lambda stream
//  from the selection core) and the solved coefficients (x_hat stream from back-substitution).
//  Scatters them into a dense N_PIX-pixel block, streamed out over a valid/ready handshake.
//  Pixel-to-slot lookup is direct, so emission runs at 1 pixel/cycle for any K_MAX.
// PARAMETERS
//  N_PIX   64  pixels per block (power of 2); AW = $clog2(N_PIX)
//  K_MAX   16  max support size (power of 2); KW = $clog2(K_MAX)
//  COEF_W  24  signed coefficient / pixel width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  start        in   1       begin coefficient collection (honoured in IDLE only)
//  k_final      in   KW+1    support size used; sampled on accepted start; 0..K_MAX
//  lambda_we    in   1       support-set write strobe
//  lambda_idx   in   KW      slot index
//  lambda_in    in   AW      pixel index for that slot
//  x_we         in   1       coefficient write strobe
//  x_idx        in   KW      slot index
//  x_val        in   COEF_W  signed coefficient
//  coef_done    in   1       back-substitution finished (1-cycle pulse)
//  pixel_valid  out  1       pixel_addr/pixel_val valid
//  pixel_ready  in   1       sink accepts pixel
//  pixel_addr   out  AW      pixel index
//  pixel_val    out  COEF_W  pixel value
//  busy         out  1       state != IDLE
//  dup_err      out  1       sticky: two slots named same pixel since last clear
//  block_done   out  1       1-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, support/map/coef storage cleared, dup_err 0.
//  Storage:
//    support[K_MAX] (AW bits), coef[K_MAX] (COEF_W), map_slot[N_PIX] (KW), map_vld[N_PIX].
//  lambda_we, accepted in IDLE/COLLECT, ignored in EMIT/DONE:
//    support[idx] <= lambda_in; map_slot[lambda_in] <= idx; map_vld[lambda_in] <= 1.
//    If map_vld[lambda_in] was set with a different slot, dup_err <= 1; last write wins.
//  States:
//    IDLE -> COLLECT on start; k_final latched; coef[] cleared to 0.
//    COLLECT: x_we writes coef[x_idx]. On coef_done -> EMIT, pixel counter p = 0.
//      x_we coincident with coef_done is written first.
//    EMIT: pixel_valid = 1, pixel_addr = p.
//      pixel_val = coef[map_slot[p]] when map_vld[p] && support[map_slot[p]] == p
//        && map_slot[p] < k_final; else 0.
//      Stale/overwritten slots therefore never leak.
//      addr/val held stable while !pixel_ready. On valid&&ready: p++, or DONE at p = N_PIX-1.
//    DONE (1 cycle): pixel_valid 0, block_done 1.
//      Clears map_vld, support, dup_err; lambda_we in this cycle is dropped. Then -> IDLE.
//  Latency: first pixel_valid the cycle after coef_done is sampled.
//    With ready held high: N_PIX+2 cycles from coef_done to block_done.
//  k_final = 0: all pixels emit 0.
//  start while busy: ignored. coef_done outside COLLECT: ignored.
//  Reset mid-EMIT: pixel_valid drops immediately; no block_done.
// CONFIGURATION
//  OMP_SCATTER_CLAMP_EN defined:
//    negative selected coefficients emit 0 (non-negative image domain).
//  Undefined: signed value passed through unmodified.
//  No other behaviour differs.
// TESTING
//  1. Lambdas slots 0..3 = pixels 5,9,0,63; x = 10,-4,7,1; k_final=4; ready=1.
//     -> p5=10, p9=-4 (0 with CLAMP_EN), p0=7, p63=1, rest 0; block_done at coef_done+66.
//  2. Same as 1 with pixel_ready toggling 1,0,0,1...
//     -> 64 accepted pixels, in order, values identical; addr/val stable while ready=0.
//  3. Slot 2 written pixel 5 then pixel 12 -> p5=0, p12=coef[2], dup_err=0.
//     Slots 0 and 1 both pixel 7 -> dup_err=1, p7=coef[1].
//  4. k_final=2 with 4 slots loaded -> only slots 0,1 pixels nonzero.
//     Next block after block_done with no lambdas -> all 64 pixels 0.
//  5. x_we and coef_done same cycle (slot 3=99) -> p(support[3])=99.
//     start pulsed during EMIT -> ignored, no restart.
//  6. rst_n low at p=30 -> pixel_valid/busy 0 next edge, no block_done.
//     Fresh block after release reconstructs correctly.

Source files
------------

// File: rtl/omp_sparse_scatter.sv
// rtl/omp_sparse_scatter.sv - OMP back end: scatter support/coefficients into a dense pixel stream
//
// Purpose:
//   Collects the support set (slot -> pixel index) and the solved coefficients
//   (slot -> value), then emits one dense N_PIX-pixel block at 1 pixel/cycle over a
//   valid/ready handshake. A pixel-indexed reverse map gives a direct pixel-to-slot
//   lookup, so emission rate does not depend on K_MAX.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, k_final             begin a block (IDLE only), support size to use
//   lambda_we/idx/in           support-set write: slot idx names pixel lambda_in
//   x_we/x_idx/x_val           coefficient write (COLLECT only)
//   coef_done                  coefficients complete, begin emission
//   pixel_valid/ready/addr/val dense output stream
//   busy                       block in progress (state != IDLE)
//   dup_err                    sticky: two slots named the same pixel
//   block_done                 one-cycle pulse after the last pixel is accepted
//
// Configuration:
//   OMP_SCATTER_CLAMP_EN  when defined, negative selected coefficients emit 0.
module omp_sparse_scatter #(
  parameter int N_PIX  = 64,
  parameter int K_MAX  = 16,
  parameter int COEF_W = 24,
  localparam int AW    = $clog2(N_PIX),
  localparam int KW    = $clog2(K_MAX)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [KW:0]              k_final,
  input  logic                     lambda_we,
  input  logic [KW-1:0]            lambda_idx,
  input  logic [AW-1:0]            lambda_in,
  input  logic                     x_we,
  input  logic [KW-1:0]            x_idx,
  input  logic signed [COEF_W-1:0] x_val,
  input  logic                     coef_done,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [AW-1:0]            pixel_addr,
  output logic signed [COEF_W-1:0] pixel_val,
  output logic                     busy,
  output logic                     dup_err,
  output logic                     block_done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  state_t                   state;
  logic [AW-1:0]            p;
  logic [KW:0]              k_lat;
  logic [AW-1:0]            support  [K_MAX];
  logic signed [COEF_W-1:0] coef     [K_MAX];
  logic [KW-1:0]            map_slot [N_PIX];
  logic [N_PIX-1:0]         map_vld;

  logic                     lambda_ok;
  logic [KW-1:0]            sel_slot;
  logic                     sel_hit;
  logic signed [COEF_W-1:0] sel_coef;

  // Support writes are frozen once emission starts so the lookup below stays stable.
  assign lambda_ok  = lambda_we && (state == IDLE || state == COLLECT);
  assign pixel_addr = p;

  // A pixel is selected only if the reverse map still agrees with the forward map
  // (a slot re-pointed elsewhere leaves a stale map entry) and the slot is in use.
  always_comb begin
    sel_slot = map_slot[p];
    sel_coef = coef[sel_slot];
    sel_hit  = map_vld[p] && (support[sel_slot] == p) && ({1'b0, sel_slot} < k_lat);
  end

  always_comb begin
    pixel_val = '0;
    if (pixel_valid && sel_hit) begin
`ifdef OMP_SCATTER_CLAMP_EN
      if (!sel_coef[COEF_W-1]) pixel_val = sel_coef;
`else
      pixel_val = sel_coef;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      k_lat       <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      dup_err     <= 1'b0;
      block_done  <= 1'b0;
      map_vld     <= '0;
      for (int i = 0; i < K_MAX; i++) begin
        support[i] <= '0;
        coef[i]    <= '0;
      end
      for (int j = 0; j < N_PIX; j++) begin
        map_slot[j] <= '0;
      end
    end else begin
      block_done <= 1'b0;

      if (lambda_ok) begin
        support[lambda_idx]  <= lambda_in;
        map_slot[lambda_in]  <= lambda_idx;
        map_vld[lambda_in]   <= 1'b1;
        if (map_vld[lambda_in] && (map_slot[lambda_in] != lambda_idx)) begin
          dup_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            busy  <= 1'b1;
            k_lat <= k_final;
            for (int i = 0; i < K_MAX; i++) begin
              coef[i] <= '0;
            end
          end
        end

        COLLECT: begin
          if (x_we) begin
            coef[x_idx] <= x_val;
          end
          if (coef_done) begin
            state       <= EMIT;
            p           <= '0;
            pixel_valid <= 1'b1;
          end
        end

        EMIT: begin
          if (pixel_ready) begin
            if (&p) begin
              state       <= DONE;
              p           <= '0;
              pixel_valid <= 1'b0;
              block_done  <= 1'b1;
            end else begin
              p <= p + AW'(1);
            end
          end
        end

        DONE: begin
          // Lambda writes are not accepted here, so this clear cannot race one.
          state   <= IDLE;
          busy    <= 1'b0;
          dup_err <= 1'b0;
          map_vld <= '0;
          for (int i = 0; i < K_MAX; i++) begin
            support[i] <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omp_sparse_scatter.sv
// tb/tb_omp_sparse_scatter.sv - directed self-checking bench for omp_sparse_scatter
module tb_omp_sparse_scatter;

  localparam int N_PIX  = 64;
  localparam int COEF_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        k_final = '0;
  logic              lambda_we = 1'b0;
  logic [3:0]        lambda_idx = '0;
  logic [5:0]        lambda_in = '0;
  logic              x_we = 1'b0;
  logic [3:0]        x_idx = '0;
  logic [23:0]       x_val = '0;
  logic              coef_done = 1'b0;
  logic              pixel_valid;
  logic              pixel_ready = 1'b0;
  logic [5:0]        pixel_addr;
  logic [23:0]       pixel_val;
  logic              busy;
  logic              dup_err;
  logic              block_done;

  int                total = 0;
  int                bad = 0;
  logic [23:0]       exp_px [N_PIX];
  int                start_at = -1;

  omp_sparse_scatter #(.N_PIX(64), .K_MAX(16), .COEF_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_final(k_final),
    .lambda_we(lambda_we), .lambda_idx(lambda_idx), .lambda_in(lambda_in),
    .x_we(x_we), .x_idx(x_idx), .x_val(x_val), .coef_done(coef_done),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_addr(pixel_addr),
    .pixel_val(pixel_val), .busy(busy), .dup_err(dup_err), .block_done(block_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp;
    for (int i = 0; i < N_PIX; i++) exp_px[i] = '0;
  endtask

  task automatic start_blk(input logic [4:0] k);
    start = 1'b1;
    k_final = k;
    tick;
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic write_lambda(input logic [3:0] idx, input logic [5:0] pix);
    lambda_we = 1'b1;
    lambda_idx = idx;
    lambda_in = pix;
    tick;
    lambda_we = 1'b0;
  endtask

  task automatic write_x(input logic [3:0] idx, input logic [23:0] v);
    x_we = 1'b1;
    x_idx = idx;
    x_val = v;
    tick;
    x_we = 1'b0;
  endtask

  // pat 0: ready held high; pat 1: ready pattern 1,0,0,1,0,0...
  task automatic emit_block(input int pat);
    int          n_acc;
    int          cyc;
    logic        got_done;
    logic        holding;
    logic [5:0]  hold_a;
    logic [23:0] hold_v;
    n_acc = 0;
    got_done = 1'b0;
    holding = 1'b0;
    hold_a = '0;
    hold_v = '0;
    coef_done = 1'b1;
    tick;
    coef_done = 1'b0;
    x_we = 1'b0;
    cyc = 1;
    while (!got_done && cyc < 400) begin
      pixel_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 1);
      start = (cyc == start_at);
      if (pixel_valid) begin
        if (holding) begin
          check("hold_addr", {26'b0, pixel_addr}, {26'b0, hold_a});
          check("hold_val", {8'b0, pixel_val}, {8'b0, hold_v});
        end
        if (pixel_ready) begin
          check("pix_addr", {26'b0, pixel_addr}, n_acc[31:0]);
          check("pix_val", {8'b0, pixel_val}, {8'b0, exp_px[n_acc % N_PIX]});
          n_acc++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          hold_a = pixel_addr;
          hold_v = pixel_val;
        end
      end
      if (block_done) begin
        got_done = 1'b1;
      end else begin
        tick;
        cyc++;
      end
    end
    start = 1'b0;
    start_at = -1;
    check("block_done_seen", {31'b0, got_done}, 32'd1);
    check("accepted_count", n_acc[31:0], 32'd64);
    check("valid_low_at_done", {31'b0, pixel_valid}, 32'd0);
    // Counting the coef_done cycle as cycle 1, block_done lands in cycle N_PIX+2.
    if (pat == 0) check("done_latency", cyc[31:0] + 32'd1, 32'(N_PIX + 2));
    tick;
    check("done_pulse_1cyc", {31'b0, block_done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);
    check("dup_cleared", {31'b0, dup_err}, 32'd0);
  endtask

  task automatic load_basic;
    write_lambda(4'd0, 6'd5);
    write_lambda(4'd1, 6'd9);
    write_lambda(4'd2, 6'd0);
    write_lambda(4'd3, 6'd63);
    write_x(4'd0, 24'd10);
    write_x(4'd1, 24'(-4));
    write_x(4'd2, 24'd7);
    write_x(4'd3, 24'd1);
  endtask

  task automatic exp_basic;
    clear_exp();
    exp_px[5] = 24'd10;
`ifdef OMP_SCATTER_CLAMP_EN
    exp_px[9] = 24'd0;
`else
    exp_px[9] = 24'(-4);
`endif
    exp_px[0] = 24'd7;
    exp_px[63] = 24'd1;
  endtask

  initial begin
    logic seen;

    // Reset state
    tick;
    check("rst_valid", {31'b0, pixel_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dup", {31'b0, dup_err}, 32'd0);
    check("rst_done", {31'b0, block_done}, 32'd0);
    check("rst_addr", {26'b0, pixel_addr}, 32'd0);
    check("rst_val", {8'b0, pixel_val}, 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: basic scatter, ready high, latency
    start_blk(5'd4);
    load_basic();
    exp_basic();
    emit_block(0);

    // 2: same block with backpressure
    start_blk(5'd4);
    load_basic();
    emit_block(1);

    // 3: slot re-pointed (no dup) and two slots on one pixel (dup)
    start_blk(5'd4);
    write_lambda(4'd2, 6'd5);
    write_lambda(4'd2, 6'd12);
    check("no_dup_repoint", {31'b0, dup_err}, 32'd0);
    write_lambda(4'd0, 6'd7);
    write_lambda(4'd1, 6'd7);
    check("dup_set", {31'b0, dup_err}, 32'd1);
    write_x(4'd0, 24'd1);
    write_x(4'd1, 24'd2);
    write_x(4'd2, 24'd3);
    clear_exp();
    exp_px[12] = 24'd3;
    exp_px[7] = 24'd2;
    emit_block(0);

    // 4: k_final limits slots; next block without lambdas is all zero
    start_blk(5'd2);
    load_basic();
    clear_exp();
    exp_px[5] = 24'd10;
`ifndef OMP_SCATTER_CLAMP_EN
    exp_px[9] = 24'(-4);
`endif
    emit_block(0);
    start_blk(5'd4);
    write_x(4'd0, 24'd5);
    clear_exp();
    emit_block(0);

    // 5: x_we coincident with coef_done; start during EMIT ignored
    start_blk(5'd4);
    write_lambda(4'd3, 6'd20);
    write_lambda(4'd0, 6'd1);
    write_x(4'd0, 24'd6);
    clear_exp();
    exp_px[20] = 24'd99;
    exp_px[1] = 24'd6;
    x_we = 1'b1;
    x_idx = 4'd3;
    x_val = 24'd99;
    k_final = 5'd0;
    start_at = 10;
    emit_block(0);
    tick;
    check("no_restart", {31'b0, busy}, 32'd0);

    // 6: reset mid-EMIT, then a fresh block
    start_blk(5'd4);
    load_basic();
    coef_done = 1'b1;
    tick;
    coef_done = 1'b0;
    pixel_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (pixel_valid && pixel_addr == 6'd30) seen = 1'b1;
      else tick;
    end
    check("reach_p30", {31'b0, seen}, 32'd1);
    rst_n = 1'b0;
    tick;
    check("rst_mid_valid", {31'b0, pixel_valid}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, block_done}, 32'd0);
    tick;
    check("rst_mid_done2", {31'b0, block_done}, 32'd0);
    rst_n = 1'b1;
    tick;
    check("post_rst_done", {31'b0, block_done}, 32'd0);
    start_blk(5'd4);
    load_basic();
    exp_basic();
    emit_block(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
